seq_signed_or_unsigned_mul: RTL and testbench

//   Iterative, area-lean N x N -> 2N multiplier. Signed/unsigned mode is selected per transaction.

---
 rtl/seq_mul_pkg.sv | 10 +
 rtl/seq_mul_step.sv | 21 ++
 rtl/seq_signed_or_unsigned_mul.sv | 119 +++++++++++
 tb/tb_seq_signed_or_unsigned_mul.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types for the iterative signed/unsigned multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } seq_mul_state_t;

endpackage

// File: rtl/seq_mul_step.sv
// One shift-add step: adds |a| times a BITS_PER_CYCLE-wide slice of |b|, shifted to the slice position.
module seq_mul_step #(
    parameter int unsigned n              = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [2*n-1:0]                         acc,
    input  logic [n-1:0]                           a_mag,
    input  logic [BITS_PER_CYCLE-1:0]              b_slice,
    input  logic [$clog2(n/BITS_PER_CYCLE+1)-1:0]  cnt,
    output logic [2*n-1:0]                         acc_next
);

    logic [2*n-1:0] pp;

    // Partial product is n+BITS_PER_CYCLE bits; the largest shift keeps it inside 2n.
    always_comb begin
        pp       = (2*n)'(a_mag) * (2*n)'(b_slice);
        acc_next = acc + (pp << (cnt * BITS_PER_CYCLE));
    end

endmodule

// File: rtl/seq_signed_or_unsigned_mul.sv
// Iterative N x N -> 2N multiplier with per-transaction signed/unsigned mode and valid/ready handshakes.
module seq_signed_or_unsigned_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned n              = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           signed_mul,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*n-1:0] res,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int unsigned ITER = n / BITS_PER_CYCLE;
    localparam int unsigned CW   = $clog2(ITER + 1);

    if ((n % BITS_PER_CYCLE) != 0) begin : g_bpc_check
        $error("BITS_PER_CYCLE must divide n");
    end

    seq_mul_state_t state_q, state_d;
    logic [n-1:0]   a_mag_q, a_mag_d;
    logic [n-1:0]   b_mag_q, b_mag_d;
    logic           neg_q, neg_d;
    logic [2*n-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*n-1:0] res_q, res_d;

    logic [n-1:0]              a_abs, b_abs;
    logic [BITS_PER_CYCLE-1:0] b_slice;
    logic [2*n-1:0]            acc_step;
    logic                      last_step;

    // Magnitude of -2^(n-1) wraps to 2^(n-1), which is still correct as an unsigned n-bit value.
    always_comb begin
        a_abs     = (signed_mul && a[n-1]) ? -a : a;
        b_abs     = (signed_mul && b[n-1]) ? -b : b;
        b_slice   = BITS_PER_CYCLE'(b_mag_q >> (cnt_q * BITS_PER_CYCLE));
        last_step = (cnt_q == CW'(ITER - 1));
    end

    seq_mul_step #(
        .n              (n),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc      (acc_q),
        .a_mag    (a_mag_q),
        .b_slice  (b_slice),
        .cnt      (cnt_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    a_mag_d = a_abs;
                    b_mag_d = b_abs;
                    neg_d   = signed_mul & (a[n-1] ^ b[n-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    res_d   = neg_q ? -acc_step : acc_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// Directed corner cases on an 8-bit instance plus randomized sweeps over several width/step configurations.
module tb_seq_signed_or_unsigned_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int sweep_done  = 0;
    logic sw_rst_n  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- directed instance, n=8, one bit per cycle ----------------
    logic        m_rst_n, m_s, m_iv, m_ir, m_ov, m_ordy;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_res;

    seq_signed_or_unsigned_mul #(
        .n              (8),
        .BITS_PER_CYCLE (1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (m_rst_n),
        .a          (m_a),
        .b          (m_b),
        .signed_mul (m_s),
        .in_valid   (m_iv),
        .in_ready   (m_ir),
        .res        (m_res),
        .out_valid  (m_ov),
        .out_ready  (m_ordy)
    );

    // Wait for out_valid after an accepting edge; inputs are scrambled meanwhile.
    task automatic m_wait_done(input string tag);
        int lat = 0;
        while (!m_ov && lat < 40) begin
            m_a = 8'($urandom);
            m_b = 8'($urandom);
            m_s = 1'($urandom);
            m_iv = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        m_iv = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'd8);
    endtask

    task automatic m_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                        input int hold, input logic [15:0] exp, input string tag);
        m_a = ta; m_b = tb_; m_s = ts; m_iv = 1'b1; m_ordy = 1'b0;
        @(posedge clk); #1;
        m_wait_done(tag);
        check({tag, "_res"}, 64'(m_res), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_ov"}, 64'(m_ov), 64'd1);
            check({tag, "_hold_ir"}, 64'(m_ir), 64'd0);
            check({tag, "_hold_res"}, 64'(m_res), 64'(exp));
        end
        m_ordy = 1'b1;
        @(posedge clk); #1;
        m_ordy = 1'b0;
        check({tag, "_ov_drop"}, 64'(m_ov), 64'd0);
    endtask

    // ---------------- randomized sweep instances ----------------
    localparam int unsigned NCFG = 11;
    localparam int unsigned CFG_N [NCFG] = '{4, 4, 4, 8, 8, 8, 8, 16, 16, 16, 16};
    localparam int unsigned CFG_B [NCFG] = '{1, 2, 4, 1, 2, 4, 8, 1, 2, 4, 8};

    for (genvar g = 0; g < NCFG; g++) begin : g_sweep
        localparam int unsigned N  = CFG_N[g];
        localparam int unsigned BP = CFG_B[g];

        logic [N-1:0]   a, b;
        logic           sm, iv, ir, ov, ordy;
        logic [2*N-1:0] res;

        seq_signed_or_unsigned_mul #(
            .n              (N),
            .BITS_PER_CYCLE (BP)
        ) u_dut (
            .clk        (clk),
            .rst_n      (sw_rst_n),
            .a          (a),
            .b          (b),
            .signed_mul (sm),
            .in_valid   (iv),
            .in_ready   (ir),
            .res        (res),
            .out_valid  (ov),
            .out_ready  (ordy)
        );

        function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                                   input logic s);
            longint xi, yi;
            xi = s ? longint'($signed(x)) : longint'(x);
            yi = s ? longint'($signed(y)) : longint'(y);
            return (2*N)'(xi * yi);
        endfunction

        initial begin
            logic [N-1:0]   ea, eb;
            logic           es;
            logic [2*N-1:0] exp;
            int             lat, w;
            bit             hs;
            a = '0; b = '0; sm = 1'b0; iv = 1'b0; ordy = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            for (int k = 0; k < 1000; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                ea = N'($urandom); eb = N'($urandom); es = 1'($urandom);
                a = ea; b = eb; sm = es; iv = 1'b1;
                check($sformatf("sw%0d_ir", g), 64'(ir), 64'd1);
                @(posedge clk); #1;
                lat = 0;
                while (!ov && lat < 60) begin
                    a = N'($urandom); b = N'($urandom); sm = 1'($urandom); iv = 1'($urandom);
                    @(posedge clk); #1;
                    lat++;
                end
                iv = 1'b0;
                exp = ref_mul(ea, eb, es);
                check($sformatf("sw%0d_lat", g), 64'(lat), 64'(N / BP));
                check($sformatf("sw%0d_res a=%0h b=%0h s=%0d", g, ea, eb, es), 64'(res), 64'(exp));
                hs = 1'b0;
                w = 0;
                while (!hs && w < 30) begin
                    ordy = ($urandom_range(0, 2) != 0);
                    check($sformatf("sw%0d_stable", g), 64'(res), 64'(exp));
                    hs = ordy;
                    @(posedge clk); #1;
                    w++;
                end
                ordy = 1'b0;
                check($sformatf("sw%0d_ov_drop", g), 64'(ov), 64'd0);
            end
            sweep_done++;
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin
        int w;
        m_rst_n = 1'b0; m_a = '0; m_b = '0; m_s = 1'b0; m_iv = 1'b0; m_ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sw_rst_n = 1'b1;
        check("rst_ir", 64'(m_ir), 64'd1);
        check("rst_ov", 64'(m_ov), 64'd0);
        check("rst_res", 64'(m_res), 64'd0);
        m_rst_n = 1'b1;

        m_op(8'hFF, 8'hFF, 1'b0, 0, 16'hFE01, "umax");
        m_op(8'hFF, 8'hFF, 1'b1, 0, 16'h0001, "s_ff_ff");
        m_op(8'h80, 8'h80, 1'b1, 0, 16'h4000, "s_80_80");
        m_op(8'h80, 8'h7F, 1'b1, 0, 16'hC080, "s_80_7f");
        m_op(8'h00, 8'h80, 1'b1, 0, 16'h0000, "s_00_80");
        m_op(8'h05, 8'hFD, 1'b1, 0, 16'hFFF1, "s_5_m3");
        m_op(8'h05, 8'hFD, 1'b0, 0, 16'h04F1, "u_5_fd");
        m_op(8'hC8, 8'h64, 1'b0, 5, 16'h4E20, "bp_hold");

        // Backpressure with a new request waiting: accepted only the cycle after the output handshake.
        m_a = 8'd12; m_b = 8'd10; m_s = 1'b0; m_iv = 1'b1;
        @(posedge clk); #1;
        m_wait_done("bp2");
        check("bp2_res", 64'(m_res), 64'd120);
        m_a = 8'd7; m_b = 8'd9; m_s = 1'b0; m_iv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp2_hold_ir", 64'(m_ir), 64'd0);
            check("bp2_hold_res", 64'(m_res), 64'd120);
        end
        m_ordy = 1'b1;
        @(posedge clk); #1;
        m_ordy = 1'b0;
        check("bp2_rel_ov", 64'(m_ov), 64'd0);
        check("bp2_rel_ir", 64'(m_ir), 64'd1);
        @(posedge clk); #1;
        check("bp2_accept", 64'(m_ir), 64'd0);
        m_wait_done("bp2_next");
        check("bp2_next_res", 64'(m_res), 64'd63);
        m_ordy = 1'b1;
        @(posedge clk); #1;
        m_ordy = 1'b0;

        // Reset three cycles into BUSY discards the op and clears res.
        m_a = 8'd13; m_b = 8'd11; m_s = 1'b0; m_iv = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        m_rst_n = 1'b0;
        @(posedge clk); #1;
        m_rst_n = 1'b1;
        check("rst_mid_ov", 64'(m_ov), 64'd0);
        check("rst_mid_ir", 64'(m_ir), 64'd1);
        check("rst_mid_res", 64'(m_res), 64'd0);
        m_op(8'h81, 8'h02, 1'b1, 0, 16'hFF02, "after_rst");

        // Reset during DONE with out_ready low drops out_valid.
        m_a = 8'd3; m_b = 8'd3; m_s = 1'b0; m_iv = 1'b1;
        @(posedge clk); #1;
        m_wait_done("rst_done");
        check("rst_done_ov_pre", 64'(m_ov), 64'd1);
        m_rst_n = 1'b0;
        @(posedge clk); #1;
        m_rst_n = 1'b1;
        check("rst_done_ov", 64'(m_ov), 64'd0);

        w = 0;
        while (sweep_done < int'(NCFG) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        check("sweep_complete", 64'(sweep_done), 64'(NCFG));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
